cve2_mem_arbiter: RTL and testbench

//  Merges the core's instruction-fetch and data-LSU request/grant/rvalid ports onto one shared memory port.

---
 rtl/cve2_pkg.sv | 8 +
 rtl/cve2_arb_id_fifo.sv | 44 ++++
 rtl/cve2_mem_arbiter.sv | 89 ++++++++
 tb/tb_cve2_mem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cve2_pkg.sv
// cve2_pkg: shared types for the instruction/data memory arbiter
package cve2_pkg;
   typedef enum logic {ArbSrcInstr = 1'b0, ArbSrcData = 1'b1} arb_src_e;
   typedef enum logic {ArbIdle = 1'b0, ArbLocked = 1'b1} arb_state_e;
   function automatic arb_src_e arb_other(arb_src_e s);
      return s == ArbSrcData ? ArbSrcInstr : ArbSrcData;
   endfunction
endpackage

// File: rtl/cve2_arb_id_fifo.sv
// cve2_arb_id_fifo: in-order record of which source owns each outstanding memory transaction
module cve2_arb_id_fifo
   import cve2_pkg::*;
#(
   parameter int Depth = 2
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push,
   input  arb_src_e wdata,
   input  logic     pop,
   output arb_src_e rdata,
   output logic     full,
   output logic     empty
);
   localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);
   arb_src_e        mem_q [Depth];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] cnt_q;
   logic            do_push, do_pop;
   function automatic logic [PtrW-1:0] inc(logic [PtrW-1:0] p);
      return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
   endfunction
   assign full    = cnt_q == CntW'(Depth);
   assign empty   = cnt_q == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rptr_q];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= inc(wptr_q);
         end
         if (do_pop) rptr_q <= inc(rptr_q);
         cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
   end
endmodule

// File: rtl/cve2_mem_arbiter.sv
// cve2_mem_arbiter: merges instruction-fetch and LSU ports onto one in-order memory port
module cve2_mem_arbiter
   import cve2_pkg::*;
#(
   parameter int MaxOutstanding = 2,
   parameter bit RoundRobin     = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        unexp_rsp_o
);
   arb_state_e state_q, state_d;
   arb_src_e   lock_src_q, rr_ptr_q, win_src, src, head_src;
   logic       fifo_full, fifo_empty, gnt, pop, unexp_q;
   assign win_src = (data_req_i && (!RoundRobin || rr_ptr_q == ArbSrcData || !instr_req_i)) ?
                    ArbSrcData : ArbSrcInstr;
   // a stalled request keeps its source so the payload never changes before grant
   assign src = state_q == ArbLocked ? lock_src_q : win_src;
   assign gnt = mem_req_o & mem_gnt_i;
   assign pop = mem_rvalid_i & ~fifo_empty;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ArbIdle;
         lock_src_q <= ArbSrcInstr;
         rr_ptr_q   <= ArbSrcData;
         unexp_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_src_q <= src;
         if (RoundRobin && gnt) rr_ptr_q <= arb_other(src);
         if (mem_rvalid_i && fifo_empty) unexp_q <= 1'b1;
      end
   end
   always_comb begin
      state_d = gnt ? ArbIdle : mem_req_o ? ArbLocked : state_q;
   end
   always_comb begin
      mem_req_o      = (instr_req_i | data_req_i) & ~fifo_full;
      mem_we_o       = src == ArbSrcData ? data_we_i    : 1'b0;
      mem_be_o       = src == ArbSrcData ? data_be_i    : 4'hF;
      mem_addr_o     = src == ArbSrcData ? data_addr_i  : instr_addr_i;
      mem_wdata_o    = src == ArbSrcData ? data_wdata_i : 32'h0;
      instr_gnt_o    = gnt & (src == ArbSrcInstr);
      data_gnt_o     = gnt & (src == ArbSrcData);
      instr_rvalid_o = pop & (head_src == ArbSrcInstr);
      data_rvalid_o  = pop & (head_src == ArbSrcData);
      instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
      data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;
      instr_err_o    = instr_rvalid_o & mem_err_i;
      data_err_o     = data_rvalid_o & mem_err_i;
      unexp_rsp_o    = unexp_q;
   end
   cve2_arb_id_fifo #(
      .Depth(MaxOutstanding)
   ) u_id_fifo (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .push (gnt),
      .wdata(src),
      .pop  (pop),
      .rdata(head_src),
      .full (fifo_full),
      .empty(fifo_empty)
   );
endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// tb_cve2_mem_arbiter: fixed-priority and round-robin arbiters against a queue-based reference model
module tb_cve2_mem_arbiter;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;
   logic [1:0]       ireq, dreq, dwe, mgnt, mrv, merr;
   logic [1:0][31:0] iaddr, daddr, dwdata, mrdata;
   logic [1:0][3:0]  dbe;
   logic [1:0]       igt, irv, ierr, dgt, drv, derr, mreq, mwe, ux_o;
   logic [1:0][31:0] irdata, drdata, maddr, mwdata;
   logic [1:0][3:0]  mbe;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      cve2_mem_arbiter #(.MaxOutstanding(2), .RoundRobin(g)) u_dut (
         .clk_i(clk_i), .rst_i(rst_i),
         .instr_req_i(ireq[g]), .instr_addr_i(iaddr[g]), .instr_gnt_o(igt[g]),
         .instr_rvalid_o(irv[g]), .instr_rdata_o(irdata[g]), .instr_err_o(ierr[g]),
         .data_req_i(dreq[g]), .data_we_i(dwe[g]), .data_be_i(dbe[g]), .data_addr_i(daddr[g]),
         .data_wdata_i(dwdata[g]), .data_gnt_o(dgt[g]), .data_rvalid_o(drv[g]),
         .data_rdata_o(drdata[g]), .data_err_o(derr[g]),
         .mem_req_o(mreq[g]), .mem_we_o(mwe[g]), .mem_be_o(mbe[g]), .mem_addr_o(maddr[g]),
         .mem_wdata_o(mwdata[g]), .mem_gnt_i(mgnt[g]), .mem_rvalid_i(mrv[g]),
         .mem_rdata_i(mrdata[g]), .mem_err_i(merr[g]), .unexp_rsp_o(ux_o[g])
      );
   end
   int n_tests = 0, n_fail = 0;
   bit lk[2], lsrc[2], ux[2], req_s[2], src_s[2], gnt_s[2], pop_s[2];
   bit rrp[2] = '{1'b1, 1'b1};
   bit q0[$], q1[$];
   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int qsz(int m);
      return m != 0 ? q1.size() : q0.size();
   endfunction
   function automatic bit qhead(int m);
      return m != 0 ? q1[0] : q0[0];
   endfunction
   task automatic tick_chk();
      #4;
      for (int m = 0; m < 2; m++) begin
         int qs = qsz(m);
         bit hd = qs > 0 ? qhead(m) : 1'b0;
         req_s[m] = (ireq[m] | dreq[m]) && qs < 2;
         src_s[m] = lk[m] ? lsrc[m] : (dreq[m] && (m == 0 || rrp[m] || !ireq[m]));
         gnt_s[m] = req_s[m] & mgnt[m];
         pop_s[m] = mrv[m] && qs > 0;
         chk($sformatf("mem_req%0d", m), mreq[m], req_s[m]);
         if (req_s[m]) begin
            chk($sformatf("mem_addr%0d", m), maddr[m], src_s[m] ? daddr[m] : iaddr[m]);
            chk($sformatf("mem_ctl%0d", m), {mwe[m], mbe[m], mwdata[m]},
                src_s[m] ? {dwe[m], dbe[m], dwdata[m]} : {1'b0, 4'hF, 32'h0});
         end
         chk($sformatf("gnt%0d", m), {igt[m], dgt[m]}, {gnt_s[m] & !src_s[m], gnt_s[m] & src_s[m]});
         chk($sformatf("rvalid%0d", m), {irv[m], drv[m]}, {pop_s[m] & !hd, pop_s[m] & hd});
         chk($sformatf("irsp%0d", m), {ierr[m], irdata[m]}, (pop_s[m] && !hd) ? {merr[m], mrdata[m]} : 33'h0);
         chk($sformatf("drsp%0d", m), {derr[m], drdata[m]}, (pop_s[m] && hd) ? {merr[m], mrdata[m]} : 33'h0);
         chk($sformatf("unexp%0d", m), ux_o[m], ux[m]);
      end
   endtask
   task automatic tick_adv();
      @(posedge clk_i);
      for (int m = 0; m < 2; m++) begin
         if (rst_i) begin
            lk[m] = 0; rrp[m] = 1; ux[m] = 0;
            if (m != 0) q1.delete(); else q0.delete();
         end else begin
            if (mrv[m] && qsz(m) == 0) ux[m] = 1;
            if (pop_s[m]) begin
               if (m != 0) void'(q1.pop_front()); else void'(q0.pop_front());
            end
            if (gnt_s[m]) begin
               if (m != 0) q1.push_back(src_s[m]); else q0.push_back(src_s[m]);
               lk[m] = 0;
               if (m == 1) rrp[m] = !src_s[m];
            end else if (req_s[m]) begin
               lk[m] = 1; lsrc[m] = src_s[m];
            end
         end
      end
      #1;
   endtask
   task automatic tick();
      tick_chk();
      tick_adv();
   endtask
   task automatic set(bit ir, logic [31:0] ia, bit dr, bit we, logic [31:0] da, bit mg, bit mr, logic [31:0] rd);
      for (int m = 0; m < 2; m++) begin
         ireq[m] = ir; iaddr[m] = ia; dreq[m] = dr; dwe[m] = we; dbe[m] = 4'h3;
         daddr[m] = da; dwdata[m] = da ^ 32'h5A5A_0000; mgnt[m] = mg; mrv[m] = mr;
         mrdata[m] = rd; merr[m] = 1'b0;
      end
   endtask
   task automatic do_reset();
      rst_i = 1'b1;
      set(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst_i = 1'b0;
   endtask
   initial begin
      set(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk_i);
      #1;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set(0, 0, k < 3, 1, 32'h100 + 32'(4 * k), 1, k > 0, 32'hA0 + 32'(k));
         tick_chk();
         for (int m = 0; m < 2; m++) begin
            chk("t1_dgnt", dgt[m], k < 3);
            chk("t1_drv", drv[m], k > 0);
            chk("t1_isilent", {igt[m], irv[m]}, 2'b00);
         end
         tick_adv();
      end
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set(1, 32'h400, 1, 0, 32'h500, 1, k > 0, 32'h11);
         tick_chk();
         chk("t2_fixed_d", dgt[0], 1'b1);
         chk("t2_rr_alt", {igt[1], dgt[1]}, k % 2 == 0 ? 2'b01 : 2'b10);
         tick_adv();
      end
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set(k < 4, 32'h200, k > 0, 1, 32'h300, k > 2, 0, 0);
         tick_chk();
         for (int m = 0; m < 2; m++) begin
            if (k < 4) chk("t3_lock_addr", maddr[m], 32'h200);
            if (k == 4) chk("t3_then_d", dgt[m], 1'b1);
         end
         tick_adv();
      end
      do_reset();
      set(1, 32'h600, 0, 0, 0, 1, 0, 0);
      tick();
      tick();
      tick_chk();
      for (int m = 0; m < 2; m++) chk("t4_full_noreq", mreq[m], 1'b0);
      tick_adv();
      set(1, 32'h600, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
      tick_chk();
      for (int m = 0; m < 2; m++) begin
         chk("t4_nobypass", mreq[m], 1'b0);
         chk("t4_route", {irv[m], irdata[m]}, {1'b1, 32'hDEAD_BEEF});
      end
      tick_adv();
      set(1, 32'h600, 0, 0, 0, 0, 0, 0);
      tick_chk();
      for (int m = 0; m < 2; m++) chk("t4_resume", mreq[m], 1'b1);
      tick_adv();
      do_reset();
      set(0, 0, 0, 0, 0, 0, 1, 32'h77);
      tick();
      set(0, 0, 0, 0, 0, 0, 0, 0);
      tick_chk();
      for (int m = 0; m < 2; m++) chk("t6_unexp", ux_o[m], 1'b1);
      tick_adv();
      set(0, 0, 1, 1, 32'h700, 1, 0, 0);
      tick();
      tick();
      do_reset();
      set(0, 0, 0, 0, 0, 0, 1, 32'h88);
      tick_chk();
      for (int m = 0; m < 2; m++) chk("t6_dropped", {irv[m], drv[m]}, 2'b00);
      tick_adv();
      set(0, 0, 0, 0, 0, 0, 0, 0);
      tick_chk();
      for (int m = 0; m < 2; m++) chk("t6_rst_unexp", ux_o[m], 1'b1);
      tick_adv();
      do_reset();
      repeat (4000) begin
         rst_i = $urandom_range(0, 99) == 0;
         for (int m = 0; m < 2; m++) begin
            if (!ireq[m] || (gnt_s[m] && !src_s[m])) begin
               ireq[m] = $urandom_range(0, 2) != 0;
               iaddr[m] = $urandom() & 32'hFFFF_FFFC;
            end
            if (!dreq[m] || (gnt_s[m] && src_s[m])) begin
               dreq[m] = $urandom_range(0, 2) != 0;
               dwe[m] = 1'($urandom_range(0, 1));
               dbe[m] = 4'($urandom());
               daddr[m] = $urandom();
               dwdata[m] = $urandom();
            end
            mgnt[m] = $urandom_range(0, 3) != 0;
            mrv[m] = qsz(m) > 0 ? 1'($urandom_range(0, 1)) : $urandom_range(0, 49) == 0;
            mrdata[m] = $urandom();
            merr[m] = $urandom_range(0, 7) == 0;
         end
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
